// File: rtl/hd44780_sequencer_if.sv
// Request/status signals on the user side and strobe/byte signals on the bytesender side.
// slave = the sequencer, master = the surrounding logic.
interface hd44780_sequencer_if;
   logic       STB_I;
   logic       i_rs;
   logic [7:0] i_data;
   logic       busy;
   logic       init_done;
   logic       o_stb;
   logic       o_rs;
   logic [7:0] o_data;
   logic       i_sender_busy;

   modport slave (
      input  STB_I, i_rs, i_data, i_sender_busy,
      output busy, init_done, o_stb, o_rs, o_data
   );

   modport master (
      output STB_I, i_rs, i_data, i_sender_busy,
      input  busy, init_done, o_stb, o_rs, o_data
   );
endinterface

// File: rtl/hd44780_sequencer.sv
// HD44780 init table player and single-byte forwarder with per-byte execution delay.
// Request accepted at edge N strobes in cycle N+1; busy=1 outside IDLE, requests then dropped.
module hd44780_sequencer #(
   parameter int unsigned T_POWERUP  = 1_200_000,
   parameter int unsigned T_LONG     = 49_200,
   parameter int unsigned T_SHORT    = 1_200,
   parameter int unsigned T_CMD      = 636,
   parameter int unsigned T_CLEAR    = 36_000,
   parameter int unsigned TIMER_BITS = 21
) (
   input  logic                CLK_I,
   input  logic                RST_I,
   hd44780_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {
      S_POWERUP = 3'd0,
      S_ISSUE   = 3'd1,
      S_WSTART  = 3'd2,
      S_WDONE   = 3'd3,
      S_DELAY   = 3'd4,
      S_IDLE    = 3'd5
   } state_t;

   localparam logic [TIMER_BITS-1:0] POWERUP_LAST = TIMER_BITS'(T_POWERUP - 1);
   localparam logic [TIMER_BITS-1:0] LONG_LAST    = TIMER_BITS'(T_LONG - 1);
   localparam logic [TIMER_BITS-1:0] SHORT_LAST   = TIMER_BITS'(T_SHORT - 1);
   localparam logic [TIMER_BITS-1:0] CMD_LAST     = TIMER_BITS'(T_CMD - 1);
   localparam logic [TIMER_BITS-1:0] CLEAR_LAST   = TIMER_BITS'(T_CLEAR - 1);
   localparam logic [TIMER_BITS-1:0] WSTART_LAST  = TIMER_BITS'(3);
   localparam logic [TIMER_BITS-1:0] TIMER_ONE    = TIMER_BITS'(1);
   localparam logic [TIMER_BITS-1:0] TIMER_MAX    = '1;

   state_t                state_q, state_d;
   logic [TIMER_BITS-1:0] timer_q, timer_d;
   logic [TIMER_BITS-1:0] delay_q, delay_d;   // holds delay-1, the terminal timer value
   logic [2:0]            idx_q, idx_d;
   logic                  init_done_q, init_done_d;
   logic                  rs_q, rs_d;
   logic [7:0]            data_q, data_d;

   function automatic logic [7:0] init_byte(input logic [2:0] i);
      case (i)
         3'd0:    init_byte = 8'h33;
         3'd1:    init_byte = 8'h32;
         3'd2:    init_byte = 8'h28;
         3'd3:    init_byte = 8'h08;
         3'd4:    init_byte = 8'h01;
         3'd5:    init_byte = 8'h06;
         3'd6:    init_byte = 8'h0C;
         default: init_byte = 8'h00;
      endcase
   endfunction

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q     <= S_POWERUP;
         timer_q     <= '0;
         delay_q     <= '0;
         idx_q       <= 3'd0;
         init_done_q <= 1'b0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         delay_q     <= delay_d;
         idx_q       <= idx_d;
         init_done_q <= init_done_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      delay_d     = delay_q;
      idx_d       = idx_q;
      init_done_d = init_done_q;
      rs_d        = rs_q;
      data_d      = data_q;
      case (state_q)
         S_POWERUP: begin
            if (timer_q == POWERUP_LAST) begin
               state_d = S_ISSUE;
               rs_d    = 1'b0;
               data_d  = init_byte(idx_q);
            end
         end
         S_ISSUE: state_d = S_WSTART;
         S_WSTART: begin
            // a sender that never acknowledges must not hang the sequence
            if (bus.i_sender_busy || timer_q == WSTART_LAST) state_d = S_WDONE;
         end
         S_WDONE: begin
            if (!bus.i_sender_busy) begin
               state_d = S_DELAY;
               if (!init_done_q && idx_q == 3'd0)
                  delay_d = LONG_LAST;
               else if (!init_done_q && idx_q == 3'd1)
                  delay_d = SHORT_LAST;
               else if (!rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03))
                  delay_d = CLEAR_LAST;
               else
                  delay_d = CMD_LAST;
            end
         end
         S_DELAY: begin
            if (timer_q == delay_q) begin
               if (!init_done_q && idx_q != 3'd6) begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_ISSUE;
                  rs_d    = 1'b0;
                  data_d  = init_byte(idx_q + 3'd1);
               end else begin
                  init_done_d = 1'b1;
                  state_d     = S_IDLE;
               end
            end
         end
         S_IDLE: begin
            if (bus.STB_I) begin
               state_d = S_ISSUE;
               rs_d    = bus.i_rs;
               data_d  = bus.i_data;
            end
         end
         default: state_d = S_POWERUP;
      endcase

      if (state_d != state_q)
         timer_d = '0;
      else if (timer_q == TIMER_MAX)
         timer_d = timer_q;
      else
         timer_d = timer_q + TIMER_ONE;
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.init_done = init_done_q;
   assign bus.o_stb     = (state_q == S_ISSUE);
   assign bus.o_rs      = rs_q;
   assign bus.o_data    = data_q;
endmodule

// File: tb/tb_hd44780_sequencer.sv
// Directed bench for hd44780_sequencer with a 16-cycle-busy bytesender model.
module tb_hd44780_sequencer;
   logic CLK_I = 1'b0;
   logic RST_I;

   hd44780_sequencer_if bus();

   hd44780_sequencer #(
      .T_POWERUP (20),
      .T_LONG    (15),
      .T_SHORT   (10),
      .T_CMD     (5),
      .T_CLEAR   (12),
      .TIMER_BITS(21)
   ) dut (
      .CLK_I(CLK_I),
      .RST_I(RST_I),
      .bus  (bus)
   );

   always #5 CLK_I = ~CLK_I;

   typedef struct {
      logic [7:0] data;
      int         gap_m;    // sender-idle to next strobe, cycles strictly between
      int         gap_nm;   // strobe to strobe when the sender never answers
   } init_vec_t;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         gap;      // sender-idle to busy low, cycles strictly between
      logic       inject;   // fire a 0x8E request while busy
   } req_vec_t;

   init_vec_t iv[7];
   req_vec_t  rq[7];

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   bcnt   = 0;
   int   seen8e = 0;
   logic model_en = 1'b1;

   always @(posedge CLK_I) cyc <= cyc + 1;

   always @(posedge CLK_I) begin
      if (bus.o_stb && model_en) bcnt <= 16;
      else if (bcnt > 0)         bcnt <= bcnt - 1;
   end
   assign bus.i_sender_busy = (bcnt != 0);

   always @(negedge CLK_I) if (bus.o_stb && bus.o_data == 8'h8E) seen8e <= seen8e + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wait_stb(input int budget, output int c);
      c = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge CLK_I);
         if (bus.o_stb) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) chk("strobe_timeout", 0, 1);
   endtask

   // which: 0 = sender idle, 1 = sequencer not busy, 2 = init_done high
   task automatic wait_cond(input int which, input int budget, output int c);
      logic hit;
      c = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge CLK_I);
         case (which)
            0:       hit = !bus.i_sender_busy;
            1:       hit = !bus.busy;
            default: hit = bus.init_done;
         endcase
         if (hit) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) chk($sformatf("wait%0d_timeout", which), 0, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"},      int'(bus.busy),      1);
      chk({tag, "_init_done"}, int'(bus.init_done), 0);
      chk({tag, "_o_stb"},     int'(bus.o_stb),     0);
      chk({tag, "_o_rs"},      int'(bus.o_rs),      0);
      chk({tag, "_o_data"},    int'(bus.o_data),    0);
   endtask

   task automatic run_init(input logic model_on, input int rel);
      int c, prev, idle, d;
      prev = 0;
      idle = 0;
      for (int i = 0; i < 7; i++) begin
         wait_stb(80, c);
         chk($sformatf("init%0d_data", i), int'(bus.o_data), int'(iv[i].data));
         chk($sformatf("init%0d_rs", i),   int'(bus.o_rs),   0);
         if (i == 0)
            chk("init_first_delay", c - rel, 20);
         else if (model_on)
            chk($sformatf("init%0d_gap", i), c - idle - 1, iv[i].gap_m);
         else
            chk($sformatf("init%0d_gap_nosender", i), c - prev, iv[i].gap_nm);
         prev = c;
         if (model_on) wait_cond(0, 40, idle);
      end
      wait_cond(2, 60, d);
      if (model_on) chk("init_done_gap", d - idle - 1, 5);
      else          chk("init_done_gap_nosender", d - prev, 11);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, idle, rel, n;
      iv[0] = '{8'h33,  0,  0};
      iv[1] = '{8'h32, 15, 21};
      iv[2] = '{8'h28, 10, 16};
      iv[3] = '{8'h08,  5, 11};
      iv[4] = '{8'h01,  5, 11};
      iv[5] = '{8'h06, 12, 18};
      iv[6] = '{8'h0C,  5, 11};

      rq[0] = '{1'b1, 8'h6D,  5, 1'b1};
      rq[1] = '{1'b0, 8'h01, 12, 1'b0};
      rq[2] = '{1'b1, 8'h01,  5, 1'b0};
      rq[3] = '{1'b0, 8'h02, 12, 1'b0};
      rq[4] = '{1'b0, 8'h03, 12, 1'b0};
      rq[5] = '{1'b0, 8'h04,  5, 1'b0};
      rq[6] = '{1'b0, 8'h80,  5, 1'b0};

      RST_I      = 1'b0;
      bus.STB_I  = 1'b0;
      bus.i_rs   = 1'b0;
      bus.i_data = 8'h00;

      repeat (3) @(negedge CLK_I);
      chk_reset("por");
      RST_I = 1'b1;
      rel   = cyc;
      run_init(1'b1, rel);

      for (int i = 0; i < 7; i++) begin
         wait_cond(1, 100, c);
         bus.STB_I  = 1'b1;
         bus.i_rs   = rq[i].rs;
         bus.i_data = rq[i].data;
         @(negedge CLK_I);
         chk($sformatf("req%0d_stb", i),  int'(bus.o_stb),  1);
         chk($sformatf("req%0d_data", i), int'(bus.o_data), int'(rq[i].data));
         chk($sformatf("req%0d_rs", i),   int'(bus.o_rs),   int'(rq[i].rs));
         chk($sformatf("req%0d_busy", i), int'(bus.busy),   1);
         if (rq[i].inject) begin
            bus.i_rs   = 1'b0;
            bus.i_data = 8'h8E;
            @(negedge CLK_I);
         end
         bus.STB_I = 1'b0;
         wait_cond(0, 40, idle);
         wait_cond(1, 40, c);
         chk($sformatf("req%0d_gap", i), c - idle - 1, rq[i].gap);
      end

      // strobe held through most of one transaction: one acceptance only
      wait_cond(1, 100, c);
      bus.STB_I  = 1'b1;
      bus.i_rs   = 1'b1;
      bus.i_data = 8'hCB;
      n = 0;
      repeat (17) begin
         @(negedge CLK_I);
         if (bus.o_stb) begin
            n++;
            chk("hold17_data", int'(bus.o_data), 8'hCB);
         end
      end
      bus.STB_I = 1'b0;
      chk("hold17_count", n, 1);

      // strobe held across the return to IDLE: accepted again there
      wait_cond(1, 100, c);
      bus.STB_I  = 1'b1;
      bus.i_rs   = 1'b0;
      bus.i_data = 8'hA5;
      n = 0;
      repeat (30) begin
         @(negedge CLK_I);
         if (bus.o_stb) n++;
      end
      bus.STB_I = 1'b0;
      chk("hold30_count", n, 2);
      wait_cond(1, 100, c);

      // reset after init, then again in the DELAY following 0x28
      RST_I = 1'b0;
      #1;
      chk("rst_after_init_done", int'(bus.init_done), 0);
      chk("rst_after_init_busy", int'(bus.busy), 1);
      repeat (2) @(negedge CLK_I);
      RST_I = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_stb(80, c);
         chk($sformatf("pre_abort%0d_data", i), int'(bus.o_data), int'(iv[i].data));
         wait_cond(0, 40, idle);
      end
      repeat (2) @(negedge CLK_I);
      @(posedge CLK_I);
      #2;
      RST_I = 1'b0;
      #1;
      chk_reset("abort");
      repeat (2) @(negedge CLK_I);
      RST_I = 1'b1;
      rel   = cyc;
      wait_stb(80, c);
      chk("restart_delay", c - rel, 20);
      chk("restart_data",  int'(bus.o_data), 8'h33);
      wait_cond(2, 400, c);

      // sender that never answers: every byte goes through the WSTART timeout
      model_en = 1'b0;
      @(negedge CLK_I);
      RST_I = 1'b0;
      repeat (2) @(negedge CLK_I);
      RST_I = 1'b1;
      rel   = cyc;
      run_init(1'b0, rel);

      chk("no_8E_strobe", seen8e, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
